// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Iteration counter width for a given operand width.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between a divider client and the divider.
interface seq_divider_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );
endinterface

// File: rtl/ripple_borrow_subtractor.sv
// N-bit combinational a-b built from a chain of full subtractors.
module ripple_borrow_subtractor #(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  logic [N:0] br;

  assign br[0] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign diff[i]  = a[i] ^ b[i] ^ br[i];
    assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
  end

  assign borrow = br[N];

endmodule

// File: rtl/seq_divider.sv
// Restoring unsigned divider: one quotient bit per RUN cycle, MSB first.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  seq_divider_if.slave  bus
);

  localparam int unsigned XW    = WIDTH + 1;
  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_t           state;
  logic [XW-1:0]    pr;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;

  logic [XW-1:0]    shifted;
  logic [XW-1:0]    diff;
  logic             borrow;
  logic [XW-1:0]    pr_next;
  logic [WIDTH-1:0] dq_next;

  // Shift {partial remainder, dividend} left; top bit of pr is always zero here.
  assign shifted = XW'({pr, dq[WIDTH-1]});

  ripple_borrow_subtractor #(.N(XW)) u_sub (
    .a      (shifted),
    .b      ({1'b0, dvs}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign pr_next = borrow ? shifted : diff;
  assign dq_next = {dq[WIDTH-2:0], ~borrow};

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pr            <= '0;
      dq            <= '0;
      dvs           <= '0;
      cnt           <= '0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
      bus.dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            dq  <= bus.dividend;
            dvs <= bus.divisor;
            pr  <= '0;
            cnt <= CNT_W'(WIDTH - 1);
            if (bus.divisor == '0) begin
              state         <= DONE;
              bus.done      <= 1'b1;
              bus.quotient  <= '1;
              bus.remainder <= bus.dividend;
              bus.dbz       <= 1'b1;
            end else begin
              state    <= RUN;
              bus.busy <= 1'b1;
            end
          end
        end
        RUN: begin
          pr  <= pr_next;
          dq  <= dq_next;
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state         <= DONE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b1;
            bus.quotient  <= dq_next;
            bus.remainder <= pr_next[WIDTH-1:0];
            bus.dbz       <= 1'b0;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed and exhaustive checks of the 4-bit sequential divider.
module tb_seq_divider;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  seq_divider_if #(.WIDTH(4)) bus ();

  seq_divider #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; observe outputs 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic [3:0] a, input logic [3:0] b);
    bus.start    = s;
    bus.dividend = a;
    bus.divisor  = b;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 4'd5, 4'd2);
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 4'd0 ||
        bus.remainder !== 4'd0 || bus.dbz !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b q=%0d r=%0d dbz=%b required 0 0 0 0 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz);
    end
    // First start is taken at the first edge after reset deasserts.
    rst = 1'b0;
    drive(1'b1, 4'd15, 4'd1);
    tick();
    drive(1'b0, 4'd0, 4'd0);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL first_start_busy: busy=%b required 1", bus.busy);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.quotient !== 4'd15 ||
        bus.remainder !== 4'd0 || bus.dbz !== 1'b0) begin
      errors++;
      $display("FAIL div_15_1: done=%b busy=%b q=%0d r=%0d dbz=%b required 1 0 15 0 0",
               bus.done, bus.busy, bus.quotient, bus.remainder, bus.dbz);
    end
    tick();
  endtask

  task automatic test_basic();
    drive(1'b1, 4'd13, 4'd4);
    tick();
    drive(1'b0, 4'd0, 4'd0);
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy_k%0d: busy=%b done=%b required 1 0", c, bus.busy, bus.done);
      end
      tick();
    end
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.quotient !== 4'd3 ||
        bus.remainder !== 4'd1 || bus.dbz !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_k5: done=%b busy=%b q=%0d r=%0d dbz=%b required 1 0 3 1 0",
               bus.done, bus.busy, bus.quotient, bus.remainder, bus.dbz);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.quotient !== 4'd3 || bus.remainder !== 4'd1) begin
      errors++;
      $display("FAIL basic_hold: done=%b q=%0d r=%0d required 0 3 1",
               bus.done, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_small_over_large();
    drive(1'b1, 4'd7, 4'd9);
    tick();
    drive(1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.done !== 1'b1 || bus.quotient !== 4'd0 || bus.remainder !== 4'd7 ||
        bus.dbz !== 1'b0) begin
      errors++;
      $display("FAIL div_7_9: done=%b q=%0d r=%0d dbz=%b required 1 0 7 0",
               bus.done, bus.quotient, bus.remainder, bus.dbz);
    end
    tick();
  endtask

  task automatic test_dbz();
    drive(1'b1, 4'd9, 4'd0);
    tick();
    drive(1'b0, 4'd0, 4'd0);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.quotient !== 4'd15 ||
        bus.remainder !== 4'd9 || bus.dbz !== 1'b1) begin
      errors++;
      $display("FAIL dbz_k1: done=%b busy=%b q=%0d r=%0d dbz=%b required 1 0 15 9 1",
               bus.done, bus.busy, bus.quotient, bus.remainder, bus.dbz);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.dbz !== 1'b1 || bus.quotient !== 4'd15) begin
      errors++;
      $display("FAIL dbz_hold: done=%b busy=%b q=%0d dbz=%b required 0 0 15 1",
               bus.done, bus.busy, bus.quotient, bus.dbz);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 4'd13, 4'd4);
    tick();
    drive(1'b0, 4'd13, 4'd4);
    tick();
    // Retrigger with new operands mid-run; also change the divisor input.
    drive(1'b1, 4'd6, 4'd2);
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy_k4: busy=%b required 1", bus.busy);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.quotient !== 4'd3 || bus.remainder !== 4'd1 || bus.dbz !== 1'b0) begin
      errors++;
      $display("FAIL b2b_done_k5: done=%b q=%0d r=%0d dbz=%b required 1 3 1 0",
               bus.done, bus.quotient, bus.remainder, bus.dbz);
    end
    tick();
    drive(1'b0, 4'd0, 4'd0);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 4'd3 || bus.remainder !== 4'd1) begin
      errors++;
      $display("FAIL b2b_ignored_in_done: busy=%b done=%b q=%0d r=%0d required 0 0 3 1",
               bus.busy, bus.done, bus.quotient, bus.remainder);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.quotient !== 4'd3 || bus.remainder !== 4'd1) begin
      errors++;
      $display("FAIL b2b_hold: busy=%b q=%0d r=%0d required 0 3 1",
               bus.busy, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_reset_mid_run();
    drive(1'b1, 4'd13, 4'd4);
    tick();
    drive(1'b0, 4'd0, 4'd0);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quotient !== 4'd0 ||
        bus.remainder !== 4'd0 || bus.dbz !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset_k3: busy=%b done=%b q=%0d r=%0d dbz=%b required 0 0 0 0 0",
               bus.busy, bus.done, bus.quotient, bus.remainder, bus.dbz);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL midrun_no_done: done=%b busy=%b required 0 0", bus.done, bus.busy);
    end
    drive(1'b1, 4'd10, 4'd3);
    tick();
    drive(1'b0, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (bus.done !== 1'b1 || bus.quotient !== 4'd3 || bus.remainder !== 4'd1 || bus.dbz !== 1'b0) begin
      errors++;
      $display("FAIL midrun_restart_k9: done=%b q=%0d r=%0d dbz=%b required 1 3 1 0",
               bus.done, bus.quotient, bus.remainder, bus.dbz);
    end
    tick();
  endtask

  task automatic test_sweep();
    int          lat;
    int          exp_lat;
    logic [3:0]  exp_q;
    logic [3:0]  exp_r;
    logic        exp_z;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          exp_q = 4'hF; exp_r = 4'(a); exp_z = 1'b1; exp_lat = 1;
        end else begin
          exp_q = 4'(a / b); exp_r = 4'(a % b); exp_z = 1'b0; exp_lat = 5;
        end
        drive(1'b1, 4'(a), 4'(b));
        tick();
        drive(1'b0, 4'(b), 4'(a));
        lat = 1;
        while (bus.done !== 1'b1 && lat < 10) begin
          tick();
          lat++;
        end
        checks++;
        if (bus.done !== 1'b1 || lat != exp_lat || bus.quotient !== exp_q ||
            bus.remainder !== exp_r || bus.dbz !== exp_z) begin
          errors++;
          $display("FAIL sweep_%0d_%0d: done=%b lat=%0d q=%0d r=%0d dbz=%b required 1 %0d %0d %0d %b",
                   a, b, bus.done, lat, bus.quotient, bus.remainder, bus.dbz,
                   exp_lat, exp_q, exp_r, exp_z);
        end
        tick();
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    drive(1'b0, 4'd0, 4'd0);
    test_reset();
    test_basic();
    test_small_over_large();
    test_dbz();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
